mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MUL_FAST, default 1: 1 = single-pass multiply; 0 = iterative 32-step shift-add multiply.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled on rising edge.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  input  32  operand A (multiplicand / dividend), from register-file rs read port.
REQ-007 rt_data  input  32  operand B (multiplier / divisor), from register-file rt read port.
REQ-008 wr_hi  input  1  MTHI: load hi from rs_data.
REQ-009 wr_lo  input  1  MTLO: load lo from rs_data.
REQ-010 busy  output  1  operation in progress; new start and wr_hi/wr_lo ignored.
REQ-011 done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-012 hi  output  32  HI register: product upper word / remainder.
REQ-013 lo  output  32  LO register: product lower word / quotient.

Function
REQ-014 States: IDLE, CALC, DONE. busy=1 in CALC only. done=1 in DONE only.
REQ-015 Accept rule: at edge E0 with start=1 and state IDLE, latch op, rs_data and rt_data; later operand changes have no effect.
REQ-016 start=1 in CALC or DONE: ignored; no queuing.
REQ-017 Iterative path (any divide; multiply with MUL_FAST=0):
- CALC for 32 cycles, edges E1..E32.
- hi/lo written at E33; state goes to DONE.
- done=1 for the cycle after E33; state returns to IDLE at E34.
REQ-018 Fast multiply (MUL_FAST=1):
- CALC for one cycle; hi/lo written at E1.
- done=1 for the cycle after E1.
REQ-019 Multiply result: {hi,lo} = full 64-bit product, signed for MULT, unsigned for MULTU.
REQ-020 DIVU: lo = floor(A/B), hi = A mod B, both unsigned.
REQ-021 DIV signedness:
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
- Sign correction is applied inside the 32 cycles; it adds no extra cycle.
REQ-022 Divide by zero (DIV, DIVU): lo = 0xFFFFFFFF, hi = dividend; latency unchanged.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-024 hi/lo stay unchanged from acceptance until the result write; intermediate state stays internal.
REQ-025 wr_hi/wr_lo in IDLE with start=0: hi/lo load rs_data at that edge; wr_hi and wr_lo together load both.
REQ-026 start and wr_hi/wr_lo at the same IDLE edge: start wins; the write is discarded.
REQ-027 wr_hi/wr_lo in CALC or DONE: ignored.
REQ-028 A start arriving in the DONE cycle is ignored; the earliest next accept is the IDLE cycle after done.

Reset
REQ-029 rst=0 at a rising edge sets state=IDLE, busy=0, done=0, hi=0, lo=0, and clears the iteration counter and operand latches.
REQ-030 rst=0 mid-CALC aborts the operation: no done pulse and no hi/lo update.
REQ-031 start asserted together with rst=0 is not accepted.
REQ-032 Operation resumes on the first edge with rst=1.

Verification
REQ-033 MULT with MUL_FAST=1, rs=0xFFFFFFFE (-2), rt=0x00000003 -> after E1: hi=0xFFFFFFFF, lo=0xFFFFFFFA; done for one cycle; busy high for one cycle.
REQ-034 MULTU with MUL_FAST=0, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 32 cycles; at E33: hi=0xFFFFFFFE, lo=0x00000001; done=1 in the following cycle only.
REQ-035 DIV cases, each completing at E33:
- rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU 100/7 in progress; at E5 drive start with new operands, wr_hi=1 and changed rs_data -> all ignored; at E33: lo=14, hi=2.
REQ-037 DIVU in progress; rst=0 at E10 -> hi=lo=0, busy=0, no done pulse; a new start at E12 runs normally to completion.
REQ-038 Idle writes:
- wr_hi=1 with rs=0x12345678 -> hi=0x12345678, lo unchanged.
- wr_lo=1 and start=1 at the same edge -> multiply proceeds; lo reflects only the product.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit with fast or iterative multiply.
module mult_div_unit #(
  parameter int MUL_FAST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_b;
  logic [63:0] r_p;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_sa;
  logic        w_sb;
  logic [32:0] w_add;
  logic [32:0] w_rs;
  logic [32:0] w_dif;
  logic        w_ge;
  logic [63:0] w_mul;
  logic [63:0] w_div;
  logic [63:0] w_fm;
  logic [63:0] w_pm;
  logic [63:0] w_prod;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_fast;
  logic        w_fin;
  // Operands are held as magnitudes; signs are reapplied on the result write.
  assign w_sa   = ~op[0] & rs_data[31];
  assign w_sb   = ~op[0] & rt_data[31];
  assign w_add  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul  = {w_add, r_p[31:1]};
  assign w_rs   = r_p[63:31];
  assign w_ge   = w_rs >= {1'b0, r_b};
  assign w_dif  = w_rs - {1'b0, r_b};
  assign w_div  = {w_ge ? w_dif[31:0] : w_rs[31:0], r_p[30:0], w_ge};
  assign w_fm   = {32'd0, r_p[31:0]} * {32'd0, r_b};
  assign w_fast = (MUL_FAST != 0) && !r_op[1];
  assign w_fin  = w_fast || r_cnt == 6'd32;
  assign w_pm   = w_fast ? w_fm : r_p;
  assign w_prod = r_neg_q ? -w_pm : w_pm;
  // A zero divisor leaves the dividend in the remainder, so only the quotient needs forcing.
  assign w_q    = r_b == 32'd0 ? 32'hFFFF_FFFF : (r_neg_q ? -r_p[31:0] : r_p[31:0]);
  assign w_r    = r_neg_r ? -r_p[63:32] : r_p[63:32];
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_op    <= op;
            r_b     <= w_sb ? -rt_data : rt_data;
            r_p     <= {32'd0, w_sa ? -rs_data : rs_data};
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
          end else begin
            if (wr_hi) r_hi <= rs_data;
            if (wr_lo) r_lo <= rs_data;
          end
        end
        CALC: begin
          if (w_fin) begin
            r_hi    <= r_op[1] ? w_r : w_prod[63:32];
            r_lo    <= r_op[1] ? w_q : w_prod[31:0];
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_p   <= r_op[1] ? w_div : w_mul;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of fast (f_*) and iterative (s_*) instances driven in lockstep.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic        f_busy, f_done, s_busy, s_done;
  logic [31:0] f_hi, f_lo, s_hi, s_lo;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  int errors = 0;
  int checks = 0;

  mult_div_unit #(.MUL_FAST(1)) u_fast (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .busy(f_busy), .done(f_done), .hi(f_hi), .lo(f_lo)
  );
  mult_div_unit #(.MUL_FAST(0)) u_slow (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one operation on both instances; E0 is the first tick below.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic wl);
    start = 1'b1; op = o; rs_data = a; rt_data = b; wr_lo = wl;
    tick();
    start = 1'b0; wr_lo = 1'b0; rs_data = 32'hDEAD_BEEF; rt_data = 32'h1357_9BDF;
    chk({tag, " f_busy@E0"}, 32'(f_busy), 32'd1);
    chk({tag, " s_busy@E0"}, 32'(s_busy), 32'd1);
    if (!o[1]) begin
      tick();
      chk({tag, " f_done@E1"}, 32'(f_done), 32'd1);
      chk({tag, " f_busy@E1"}, 32'(f_busy), 32'd0);
      chk({tag, " f_hi@E1"}, f_hi, eh);
      chk({tag, " f_lo@E1"}, f_lo, el);
      repeat (31) tick();
    end else repeat (32) tick();
    chk({tag, " s_busy@E32"}, 32'(s_busy), 32'd1);
    chk({tag, " s_done@E32"}, 32'(s_done), 32'd0);
    chk({tag, " s_hi held"}, s_hi, prev_hi);
    chk({tag, " s_lo held"}, s_lo, prev_lo);
    tick();
    chk({tag, " s_done@E33"}, 32'(s_done), 32'd1);
    chk({tag, " s_busy@E33"}, 32'(s_busy), 32'd0);
    chk({tag, " s_hi"}, s_hi, eh);
    chk({tag, " s_lo"}, s_lo, el);
    if (o[1]) begin
      chk({tag, " f_done@E33"}, 32'(f_done), 32'd1);
      chk({tag, " f_hi"}, f_hi, eh);
      chk({tag, " f_lo"}, f_lo, el);
      start = 1'b1; op = 2'b11; rs_data = 32'd9; rt_data = 32'd3; wr_hi = 1'b1;
    end
    tick();
    start = 1'b0; wr_hi = 1'b0;
    chk({tag, " s_done@E34"}, 32'(s_done), 32'd0);
    chk({tag, " f_done@E34"}, 32'(f_done), 32'd0);
    chk({tag, " s_busy@E34"}, 32'(s_busy), 32'd0);
    chk({tag, " f_busy@E34"}, 32'(f_busy), 32'd0);
    chk({tag, " s_hi@E34"}, s_hi, eh);
    chk({tag, " f_hi@E34"}, f_hi, eh);
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    start = 1'b1; wr_hi = 1'b1; rs_data = 32'hFFFF_FFFF; rt_data = 32'd5;
    repeat (2) tick();
    chk("reset f_busy", 32'(f_busy), 32'd0);
    chk("reset s_busy", 32'(s_busy), 32'd0);
    chk("reset f_done", 32'(f_done), 32'd0);
    chk("reset f_hi", f_hi, 32'd0);
    chk("reset s_lo", s_lo, 32'd0);
    rst = 1'b1; start = 1'b0; wr_hi = 1'b0;
    tick();
    chk("post-reset idle", 32'(s_busy), 32'd0);

    run("MULT -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run("MULTU max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run("MULT minint^2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run("MULT 7*-5", 2'b00, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 1'b0);
    run("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("DIVU 100/0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0);
    run("DIV minint/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run("DIVU max/10", 2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 1'b0);
    run("DIV -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

    // Start, MTHI and operand changes mid-divide must all be ignored.
    start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = 2'b00; rs_data = 32'd55; rt_data = 32'd3; wr_hi = 1'b1;
    tick();
    start = 1'b0; wr_hi = 1'b0;
    repeat (27) tick();
    chk("E5 ignore s_busy@E32", 32'(s_busy), 32'd1);
    chk("E5 ignore s_hi held", s_hi, prev_hi);
    tick();
    chk("E5 ignore s_done", 32'(s_done), 32'd1);
    chk("E5 ignore s_lo", s_lo, 32'd14);
    chk("E5 ignore s_hi", s_hi, 32'd2);
    chk("E5 ignore f_lo", f_lo, 32'd14);
    chk("E5 ignore f_hi", f_hi, 32'd2);
    tick();
    chk("E5 ignore idle", 32'(f_busy), 32'd0);

    // Reset at E10 aborts a divide with no done pulse.
    start = 1'b1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort s_hi", s_hi, 32'd0);
    chk("abort s_lo", s_lo, 32'd0);
    chk("abort f_lo", f_lo, 32'd0);
    chk("abort s_busy", 32'(s_busy), 32'd0);
    chk("abort s_done", 32'(s_done), 32'd0);
    tick();
    chk("abort no done", 32'(s_done), 32'd0);
    chk("abort no done f", 32'(f_done), 32'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    run("DIVU 1000/7 after abort", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);

    wr_hi = 1'b1; rs_data = 32'h1234_5678;
    tick();
    wr_hi = 1'b0;
    chk("MTHI s_hi", s_hi, 32'h1234_5678);
    chk("MTHI f_hi", f_hi, 32'h1234_5678);
    chk("MTHI s_lo kept", s_lo, 32'd142);
    wr_hi = 1'b1; wr_lo = 1'b1; rs_data = 32'hCAFE_F00D;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("MTHI+MTLO hi", s_hi, 32'hCAFE_F00D);
    chk("MTHI+MTLO lo", f_lo, 32'hCAFE_F00D);
    prev_hi = 32'hCAFE_F00D;
    prev_lo = 32'hCAFE_F00D;
    run("MULTU 3*4 with MTLO", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
